// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-requester MMIO arbiter.
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef logic req_idx_t;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way combinational grant selection. Round-robin by default; with
// MMIO_ARB_FIXED_PRI_EN defined, requester 0 always wins contention.
module rr_arb2
    import mmio_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  req_idx_t last_grant_i,
    output logic     gnt_valid_o,
    output req_idx_t gnt_idx_o
);

    assign gnt_valid_o = req0_i | req1_i;

`ifdef MMIO_ARB_FIXED_PRI_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign gnt_idx_o         = req0_i ? 1'b0 : 1'b1;
`else
    always_comb begin
        if (req0_i && req1_i) begin
            // Whoever was not served last goes next.
            gnt_idx_o = ~last_grant_i;
        end else begin
            gnt_idx_o = req0_i ? 1'b0 : 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO slave register port between two requesters (m0, m1).
// Build option MMIO_ARB_FIXED_PRI_EN replaces round-robin with fixed m0 priority.
//
// state  | meaning
// IDLE   | slave port quiet; sample requests, latch winner's fields
// ACCESS | cs + read/write held for HOLD_CYCLES cycles
// RESP   | one-cycle ack to the granted requester
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              cs,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    req_idx_t          gidx_q, gidx_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              gnt_valid;
    req_idx_t          gnt_idx;
    req_idx_t          last_grant;

`ifdef MMIO_ARB_FIXED_PRI_EN
    assign last_grant = 1'b1;
`else
    req_idx_t last_grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (state_q == RESP) begin
            last_grant_q <= gidx_q;
        end
    end

    assign last_grant = last_grant_q;
`endif

    rr_arb2 u_arb (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            gidx_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gidx_q     <= gidx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        gidx_d     = gidx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gidx_d  = gnt_idx;
                    wr_d    = gnt_idx ? m1_wr    : m0_wr;
                    addr_d  = gnt_idx ? m1_addr  : m0_addr;
                    wdata_d = gnt_idx ? m1_wdata : m0_wdata;
                    hold_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        if (gidx_q) begin
                            m1_rdata_d = rd_data;
                        end else begin
                            m0_rdata_d = rd_data;
                        end
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slave-side outputs are gated so the port reads all-zero outside ACCESS.
    assign cs       = (state_q == ACCESS);
    assign read     = cs & ~wr_q;
    assign write    = cs & wr_q;
    assign reg_addr = cs ? addr_q  : '0;
    assign wr_data  = cs ? wdata_q : '0;

    assign m0_ack   = (state_q == RESP) && (gidx_q == 1'b0);
    assign m1_ack   = (state_q == RESP) && (gidx_q == 1'b1);
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Shares one MMIO slave register port (cs/read/write/reg_addr/wr_data/rd_data, as on gpio_core) between two requesters.
- Typical use: the Microblaze bus (m0) and a hardware sequencer/debug master (m1) both access one GPIO core.
- Sequences each transfer through a small FSM and returns read data with a single-cycle ack.
- Arbitration is round-robin by default.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- HOLD_CYCLES, 1, number of cycles cs plus read/write stay asserted per transfer (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  requester 0 transfer request (level)
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  register address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid with m0_ack, held until next m0 read completes
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to m0
- cs  out  1  slave chip select
- read  out  1  slave read strobe
- write  out  1  slave write strobe
- reg_addr  out  ADDR_W  slave register address
- wr_data  out  DATA_W  slave write data
- rd_data  in  DATA_W  slave read data (combinational from slave)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - FSM = IDLE.
  - cs, read, write, m0_ack, m1_ack = 0.
  - reg_addr, wr_data, m0_rdata, m1_rdata = 0.
  - last_grant = 1, so m0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples m0_req and m1_req at each edge.
  - On any request: selects a winner, latches its wr/addr/wdata, records grant index, goes to ACCESS.
  - Slave outputs stay 0 while in IDLE.
- ACCESS:
  - cs = 1 for exactly HOLD_CYCLES cycles.
  - read = !wr_latched, write = wr_latched.
  - reg_addr and wr_data driven from the latches.
  - Hold counter counts 0..HOLD_CYCLES-1.
  - At the edge ending the last ACCESS cycle, rd_data is captured into the granted requester's rdata register (reads only), then the FSM goes to RESP.
- RESP:
  - Slave outputs = 0.
  - The granted requester's ack = 1 for this single cycle.
  - last_grant is updated.
  - Next state is IDLE unconditionally.
- Latency: request sampled at edge k; cs is high in cycles k+1..k+HOLD_CYCLES; ack is in cycle k+HOLD_CYCLES+1. Minimum period per transfer is HOLD_CYCLES+2 cycles.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the requester not in last_grant wins (round-robin, starvation-free).
- Request rules:
  - Requester holds req and fields until it sees ack, then drops req in the following cycle.
  - req still high in the IDLE cycle after RESP is a new transfer.
  - Requests are ignored outside IDLE; field changes after the latch have no effect.
  - req deasserted mid-transfer does not abort; the transfer completes and ack still fires.
- Data rules:
  - Writes do not modify rdata registers.
  - The non-granted requester's ack and rdata are unchanged.
- Reset mid-transfer: immediate return to the reset state; the in-flight transfer is dropped with no ack. A slave write may or may not have taken effect.
- Widths: the address and data buses pass through unmodified; there is no address decoding.

Optional Feature:
- Macro: MMIO_ARB_FIXED_PRI_EN.
- Defined: m0 always wins when both requesters are active; last_grant is not implemented; m1 can starve.
- Undefined: round-robin as specified above.

Decomposition:
- Package mmio_arb_pkg contains:
  - typedef enum for states (IDLE, ACCESS, RESP)
  - requester index typedef (1 bit)
  - default ADDR_W/DATA_W constants
- Sub-module rr_arb2: combinational two-way grant selection from (req0, req1, last_grant). It also contains the MMIO_ARB_FIXED_PRI_EN compile-time branch.

Test Plan:
- m0 write, HOLD_CYCLES=1, addr 0x02, data 0xA9 -> cs=write=1 for one cycle with reg_addr=0x02, wr_data=0xA9; m0_ack pulses 2 cycles after the sampling edge; m1_ack stays 0.
- m1 read of addr 0x01 with slave rd_data=0x85 -> m1_rdata=0x85 when m1_ack=1; m0_rdata unchanged; read=1 and write=0 during ACCESS.
- m0 and m1 requesting on the same edge, each held for 4 transfers -> grants alternate m0,m1,m0,m1 (with MMIO_ARB_FIXED_PRI_EN: all m0 first).
- HOLD_CYCLES=3, m0 write 0x78 -> cs high exactly 3 consecutive cycles; ack in cycle 4 after sampling.
- m0 read in flight, reset asserted during ACCESS -> cs/read drop asynchronously; no m0_ack; after release, m0 wins the next contention.
- m0_req dropped during ACCESS -> transfer completes and m0_ack still pulses once; no second transfer is started.
